// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 execute stage: datapath width, iteration
// count of the multiply/divide unit, opcode and funct encodings, ALU control
// and multiply/divide FSM state types, plus a small decode helper.
package mips_pkg;

  localparam int DATA_W  = 32;
  localparam int MD_ITER = 32;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  // R-type funct codes
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    ADD   = 2'b00,
    SUB   = 2'b01,
    RTYPE = 2'b10,
    ITYPE = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  // mult/multu/div/divu occupy funct 18..1B
  function automatic logic is_muldiv(input logic [5:0] funct);
    return funct[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle on
// operand magnitudes; signs are applied when the last step writes HI/LO.
//
// state   | meaning
// --------+-----------------------------------------------------------
// MD_IDLE | waiting; a start latches |operands| and signs, stalls now
// MD_BUSY | MD_ITER iteration cycles, stall held; last one writes hi/lo
// MD_DONE | op retires (stall low); always returns to MD_IDLE
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   start_i     muldiv instruction present in EX
//   op_i        funct[1:0]: 00 mult, 01 multu, 10 div, 11 divu
//   rs_i, rt_i  operands (rs = multiplicand/dividend, rt = multiplier/divisor)
//   stall_o     hold the front end
//   hi_o, lo_o  HI/LO registers
module muldiv_unit
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] rs_i,
  input  logic [DATA_W-1:0] rt_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  md_state_e         state_q, state_d;
  logic [4:0]        count_q, count_d;
  logic [DATA_W-1:0] a_q, a_d;        // multiplicand or divisor magnitude
  logic [DATA_W-1:0] p_hi_q, p_hi_d;  // partial product high / remainder
  logic [DATA_W-1:0] p_lo_q, p_lo_d;  // multiplier / dividend -> quotient
  logic              is_div_q, is_div_d;
  logic              qneg_q, qneg_d;  // product or quotient is negative
  logic              rneg_q, rneg_d;  // remainder follows dividend sign
  logic              dz_q, dz_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

  logic              a_neg, b_neg;
  logic [DATA_W-1:0] rs_abs, rt_abs;
  logic [DATA_W:0]   mul_sum, rem_sh, diff;
  logic [DATA_W-1:0] step_hi, step_lo;
  logic [2*DATA_W-1:0] product, prod_fix;
  logic [DATA_W-1:0] quot_fix, rem_fix;

  always_comb begin
    a_neg  = ~op_i[0] & rs_i[DATA_W-1];
    b_neg  = ~op_i[0] & rt_i[DATA_W-1];
    rs_abs = a_neg ? -rs_i : rs_i;
    rt_abs = b_neg ? -rt_i : rt_i;

    mul_sum = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, a_q} : '0);
    // Restoring step: diff[DATA_W] set means the trial subtraction underflowed
    rem_sh  = {p_hi_q, p_lo_q[DATA_W-1]};
    diff    = rem_sh - {1'b0, a_q};

    if (is_div_q) begin
      step_hi = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
      step_lo = {p_lo_q[DATA_W-2:0], ~diff[DATA_W]};
    end else begin
      step_hi = mul_sum[DATA_W:1];
      step_lo = {mul_sum[0], p_lo_q[DATA_W-1:1]};
    end

    product  = {step_hi, step_lo};
    prod_fix = qneg_q ? -product : product;
    // Divide by zero: quotient saturates, remainder is the dividend itself
    quot_fix = dz_q ? '1 : (qneg_q ? -step_lo : step_lo);
    rem_fix  = rneg_q ? -step_hi : step_hi;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    a_d      = a_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d  = MD_BUSY;
          count_d  = '0;
          is_div_d = op_i[1];
          a_d      = op_i[1] ? rt_abs : rs_abs;
          p_hi_d   = '0;
          p_lo_d   = op_i[1] ? rs_abs : rt_abs;
          qneg_d   = a_neg ^ b_neg;
          rneg_d   = a_neg;
          dz_d     = op_i[1] & (rt_i == '0);
        end
      end
      MD_BUSY: begin
        p_hi_d  = step_hi;
        p_lo_d  = step_lo;
        count_d = count_q + 5'd1;
        if (count_q == 5'(MD_ITER - 1)) begin
          state_d = MD_DONE;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MD_IDLE;
      count_q  <= '0;
      a_q      <= '0;
      p_hi_q   <= '0;
      p_lo_q   <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      a_q      <= a_d;
      p_hi_q   <= p_hi_d;
      p_lo_q   <= p_lo_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign stall_o = (state_q == MD_BUSY) || ((state_q == MD_IDLE) && start_i);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS32 execute stage: combinational ALU, branch/jump resolution and the
// iterative multiply/divide unit (the only sequential path).
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   alu_src_in, reg_dst_in        B operand select, destination select
//   branch_in, jump_in, jump_reg_in  control-flow type
//   alu_op_in, opcode_in, funct_in   ALU control
//   pc4_in, rdata1_in, rdata2_in, imm_ext_in, instr_index_in, rt_in, rd_in
//   alu_result_out, store_data_out, write_reg_out   to EX/MEM
//   redirect_out, redirect_pc_out  PC redirect on taken branch/jump
//   ex_stall_out                   front-end hold while mult/div is busy
module ex_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_src_in,
  input  logic              reg_dst_in,
  input  logic              branch_in,
  input  logic              jump_in,
  input  logic              jump_reg_in,
  input  logic [1:0]        alu_op_in,
  input  logic [5:0]        opcode_in,
  input  logic [5:0]        funct_in,
  input  logic [DATA_W-1:0] pc4_in,
  input  logic [DATA_W-1:0] rdata1_in,
  input  logic [DATA_W-1:0] rdata2_in,
  input  logic [DATA_W-1:0] imm_ext_in,
  input  logic [25:0]       instr_index_in,
  input  logic [4:0]        rt_in,
  input  logic [4:0]        rd_in,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] store_data_out,
  output logic [4:0]        write_reg_out,
  output logic              redirect_out,
  output logic [DATA_W-1:0] redirect_pc_out,
  output logic              ex_stall_out
);

  logic [DATA_W-1:0] op_a, op_b, sum_ab, diff_ab, alu_res;
  logic [DATA_W-1:0] hi, lo;
  logic [4:0]        shamt;
  logic              md_start, md_stall, br_taken;

  assign op_a    = rdata1_in;
  assign op_b    = alu_src_in ? imm_ext_in : rdata2_in;
  assign sum_ab  = op_a + op_b;
  assign diff_ab = op_a - op_b;
  assign shamt   = imm_ext_in[10:6];

  assign md_start = (alu_op_e'(alu_op_in) == RTYPE) && is_muldiv(funct_in);

  muldiv_unit u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (md_start),
    .op_i    (funct_in[1:0]),
    .rs_i    (rdata1_in),
    .rt_i    (rdata2_in),
    .stall_o (md_stall),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  always_comb begin
    alu_res = sum_ab;
    case (alu_op_e'(alu_op_in))
      ADD: alu_res = sum_ab;
      SUB: alu_res = diff_ab;
      RTYPE: begin
        case (funct_in)
          F_ADD, F_ADDU: alu_res = sum_ab;
          F_SUB, F_SUBU: alu_res = diff_ab;
          F_AND:  alu_res = op_a & op_b;
          F_OR:   alu_res = op_a | op_b;
          F_XOR:  alu_res = op_a ^ op_b;
          F_NOR:  alu_res = ~(op_a | op_b);
          F_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
          F_SLTU: alu_res = {31'd0, op_a < op_b};
          F_SLL:  alu_res = op_b << shamt;
          F_SRL:  alu_res = op_b >> shamt;
          F_SRA:  alu_res = 32'($signed(op_b) >>> shamt);
          F_MFHI: alu_res = hi;
          F_MFLO: alu_res = lo;
          default: alu_res = sum_ab;
        endcase
      end
      ITYPE: begin
        case (opcode_in)
          OP_ANDI:  alu_res = op_a & op_b;
          OP_ORI:   alu_res = op_a | op_b;
          OP_XORI:  alu_res = op_a ^ op_b;
          OP_SLTI:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
          OP_SLTIU: alu_res = {31'd0, op_a < op_b};
          OP_LUI:   alu_res = {op_b[15:0], 16'd0};
          default:  alu_res = sum_ab;
        endcase
      end
      default: alu_res = sum_ab;
    endcase
  end

  assign br_taken = branch_in &&
                    (((opcode_in == OP_BEQ) && (op_a == op_b)) ||
                     ((opcode_in == OP_BNE) && (op_a != op_b)));

  always_comb begin
    if (jump_reg_in)
      redirect_pc_out = rdata1_in;
    else if (jump_in)
      redirect_pc_out = {pc4_in[31:28], instr_index_in, 2'b00};
    else
      redirect_pc_out = pc4_in + (imm_ext_in << 2);
  end

  // A control-flow instruction waiting behind a busy mult/div must not
  // redirect until the stall has released.
  assign redirect_out   = (jump_reg_in || jump_in || br_taken) && !md_stall;
  assign ex_stall_out   = md_stall;
  assign alu_result_out = alu_res;
  assign store_data_out = rdata2_in;
  assign write_reg_out  = reg_dst_in ? rd_in : rt_in;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic        clk, rst_n;
  logic        alu_src_in, reg_dst_in, branch_in, jump_in, jump_reg_in;
  logic [1:0]  alu_op_in;
  logic [5:0]  opcode_in, funct_in;
  logic [31:0] pc4_in, rdata1_in, rdata2_in, imm_ext_in;
  logic [25:0] instr_index_in;
  logic [4:0]  rt_in, rd_in;
  logic [31:0] alu_result_out, store_data_out, redirect_pc_out;
  logic [4:0]  write_reg_out;
  logic        redirect_out, ex_stall_out;

  int checks = 0;
  int errors = 0;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .alu_src_in(alu_src_in), .reg_dst_in(reg_dst_in), .branch_in(branch_in),
    .jump_in(jump_in), .jump_reg_in(jump_reg_in), .alu_op_in(alu_op_in),
    .opcode_in(opcode_in), .funct_in(funct_in), .pc4_in(pc4_in),
    .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .imm_ext_in(imm_ext_in),
    .instr_index_in(instr_index_in), .rt_in(rt_in), .rd_in(rd_in),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out),
    .write_reg_out(write_reg_out), .redirect_out(redirect_out),
    .redirect_pc_out(redirect_pc_out), .ex_stall_out(ex_stall_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    alu_src_in = 0; reg_dst_in = 0; branch_in = 0; jump_in = 0; jump_reg_in = 0;
    alu_op_in = 2'b00; opcode_in = 6'h00; funct_in = 6'h00;
    pc4_in = 0; rdata1_in = 0; rdata2_in = 0; imm_ext_in = 0;
    instr_index_in = 0; rt_in = 0; rd_in = 0;
  endtask

  // Issue a mult/div at a negedge and count stall cycles until release.
  // Returns with inputs cleared in the retire (stall-low) cycle.
  task automatic run_md(input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, output int cycles);
    @(negedge clk);
    clear_inputs();
    alu_op_in = 2'b10; funct_in = f; rdata1_in = a; rdata2_in = b;
    #1;
    cycles = 0;
    if (ex_stall_out === 1'b1) begin
      cycles = 1;
      for (int g = 0; g < 100; g++) begin
        @(negedge clk);
        if (ex_stall_out === 1'b1) cycles++;
        else break;
      end
      if (cycles >= 100) cycles = -1;
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    #12;
    checks++; if (ex_stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", ex_stall_out); end
    checks++; if (redirect_out !== 1'b0) begin errors++; $display("FAIL reset_redirect got %0b want 0", redirect_out); end
    checks++; if (alu_result_out !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", alu_result_out); end
    @(negedge clk);
    rst_n = 1;
    alu_op_in = 2'b10; funct_in = 6'h10; #1;
    checks++; if (alu_result_out !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", alu_result_out); end
    funct_in = 6'h12; #1;
    checks++; if (alu_result_out !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", alu_result_out); end
  endtask

  task automatic test_add();
    @(negedge clk);
    clear_inputs();
    alu_op_in = 2'b10; funct_in = 6'h20; rdata1_in = 5; rdata2_in = 7;
    reg_dst_in = 1; rd_in = 5'd9; rt_in = 5'd3;
    #1;
    checks++; if (alu_result_out !== 32'd12) begin errors++; $display("FAIL add_result got %h want 0000000c", alu_result_out); end
    checks++; if (write_reg_out !== 5'd9) begin errors++; $display("FAIL add_wreg_rd got %0d want 9", write_reg_out); end
    checks++; if (ex_stall_out !== 1'b0 || redirect_out !== 1'b0) begin errors++; $display("FAIL add_ctrl stall %0b redirect %0b want 0 0", ex_stall_out, redirect_out); end
    checks++; if (store_data_out !== 32'd7) begin errors++; $display("FAIL add_store got %h want 00000007", store_data_out); end
    reg_dst_in = 0; #1;
    checks++; if (write_reg_out !== 5'd3) begin errors++; $display("FAIL add_wreg_rt got %0d want 3", write_reg_out); end
  endtask

  typedef struct packed {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [5:0]  opc;
    logic        src;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  task automatic test_alu();
    vec_t v[15];
    v[0]  = '{2'b10, 6'h22, 6'h00, 1'b0, 32'd5,        32'd7,        32'h0,        32'hFFFF_FFFE};
    v[1]  = '{2'b10, 6'h24, 6'h00, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0,       32'h0000_F000};
    v[2]  = '{2'b10, 6'h27, 6'h00, 1'b0, 32'h0,        32'h0,        32'h0,        32'hFFFF_FFFF};
    v[3]  = '{2'b10, 6'h2A, 6'h00, 1'b0, 32'hFFFF_FFFF, 32'd1,       32'h0,        32'd1};
    v[4]  = '{2'b10, 6'h2B, 6'h00, 1'b0, 32'hFFFF_FFFF, 32'd1,       32'h0,        32'd0};
    v[5]  = '{2'b10, 6'h03, 6'h00, 1'b0, 32'h0,        32'h8000_0000, 32'h100,     32'hF800_0000};
    v[6]  = '{2'b10, 6'h02, 6'h00, 1'b0, 32'h0,        32'h8000_0000, 32'h100,     32'h0800_0000};
    v[7]  = '{2'b10, 6'h00, 6'h00, 1'b0, 32'h0,        32'd1,        32'h7C0,      32'h8000_0000};
    v[8]  = '{2'b11, 6'h00, 6'h0F, 1'b1, 32'h0,        32'h0,        32'h0000_1234, 32'h1234_0000};
    v[9]  = '{2'b11, 6'h00, 6'h0D, 1'b1, 32'h0000_00F0, 32'h0,       32'h0000_000F, 32'h0000_00FF};
    v[10] = '{2'b11, 6'h00, 6'h0B, 1'b1, 32'd5,        32'h0,        32'hFFFF_FFFF, 32'd1};
    v[11] = '{2'b11, 6'h00, 6'h0A, 1'b1, 32'd5,        32'h0,        32'hFFFF_FFFF, 32'd0};
    v[12] = '{2'b01, 6'h00, 6'h00, 1'b0, 32'd0,        32'd1,        32'h0,        32'hFFFF_FFFF};
    v[13] = '{2'b00, 6'h00, 6'h00, 1'b0, 32'hFFFF_FFFF, 32'd2,       32'h0,        32'd1};
    v[14] = '{2'b10, 6'h21, 6'h00, 1'b0, 32'h7FFF_FFFF, 32'd1,       32'h0,        32'h8000_0000};
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      clear_inputs();
      alu_op_in = v[i].op; funct_in = v[i].funct; opcode_in = v[i].opc;
      alu_src_in = v[i].src; rdata1_in = v[i].a; rdata2_in = v[i].b; imm_ext_in = v[i].imm;
      #1;
      checks++;
      if (alu_result_out !== v[i].exp) begin
        errors++;
        $display("FAIL alu_vec%0d got %h want %h", i, alu_result_out, v[i].exp);
      end
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    clear_inputs();
    branch_in = 1; opcode_in = 6'h04; rdata1_in = 3; rdata2_in = 3; pc4_in = 32'h100; imm_ext_in = 4;
    #1;
    checks++; if (redirect_out !== 1'b1) begin errors++; $display("FAIL beq_taken got %0b want 1", redirect_out); end
    checks++; if (redirect_pc_out !== 32'h110) begin errors++; $display("FAIL beq_target got %h want 00000110", redirect_pc_out); end
    rdata2_in = 4; #1;
    checks++; if (redirect_out !== 1'b0) begin errors++; $display("FAIL beq_not_taken got %0b want 0", redirect_out); end
    opcode_in = 6'h05; imm_ext_in = 32'hFFFF_FFFF; #1;
    checks++; if (redirect_out !== 1'b1) begin errors++; $display("FAIL bne_taken got %0b want 1", redirect_out); end
    checks++; if (redirect_pc_out !== 32'h0FC) begin errors++; $display("FAIL bne_back_target got %h want 000000fc", redirect_pc_out); end
    rdata2_in = 3; #1;
    checks++; if (redirect_out !== 1'b0) begin errors++; $display("FAIL bne_not_taken got %0b want 0", redirect_out); end
    clear_inputs();
    jump_in = 1; pc4_in = 32'hA000_0004; instr_index_in = 26'h000_0010; #1;
    checks++; if (redirect_out !== 1'b1 || redirect_pc_out !== 32'hA000_0040) begin errors++; $display("FAIL j_target redirect %0b pc %h want 1 a0000040", redirect_out, redirect_pc_out); end
    clear_inputs();
    jump_reg_in = 1; rdata1_in = 32'h0000_1234; #1;
    checks++; if (redirect_out !== 1'b1 || redirect_pc_out !== 32'h0000_1234) begin errors++; $display("FAIL jr_target redirect %0b pc %h want 1 00001234", redirect_out, redirect_pc_out); end
  endtask

  task automatic test_mult();
    int n;
    run_md(6'h18, 32'hFFFF_FFFD, 32'd7, n);
    checks++; if (n != 33) begin errors++; $display("FAIL mult_stall_cycles got %0d want 33", n); end
    @(negedge clk);
    alu_op_in = 2'b10; funct_in = 6'h12; #1;
    checks++; if (alu_result_out !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo got %h want ffffffeb", alu_result_out); end
    checks++; if (ex_stall_out !== 1'b0) begin errors++; $display("FAIL mult_restart got stall %0b want 0", ex_stall_out); end
    funct_in = 6'h10; #1;
    checks++; if (alu_result_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", alu_result_out); end
    run_md(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    @(negedge clk);
    alu_op_in = 2'b10; funct_in = 6'h10; #1;
    checks++; if (alu_result_out !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", alu_result_out); end
    funct_in = 6'h12; #1;
    checks++; if (alu_result_out !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", alu_result_out); end
  endtask

  typedef struct packed {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } dvec_t;

  task automatic test_div();
    dvec_t d[6];
    int n;
    d[0] = '{6'h1A, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    d[1] = '{6'h1B, 32'd10,        32'd0,         32'h0000_000A, 32'hFFFF_FFFF};
    d[2] = '{6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    d[3] = '{6'h1A, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    d[4] = '{6'h1B, 32'hFFFF_FFFF, 32'd3,         32'h0,         32'h5555_5555};
    d[5] = '{6'h1A, 32'd7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD};
    for (int i = 0; i < 6; i++) begin
      run_md(d[i].f, d[i].a, d[i].b, n);
      checks++; if (n != 33) begin errors++; $display("FAIL div%0d_stall_cycles got %0d want 33", i, n); end
      @(negedge clk);
      alu_op_in = 2'b10; funct_in = 6'h12; #1;
      checks++; if (alu_result_out !== d[i].lo) begin errors++; $display("FAIL div%0d_lo got %h want %h", i, alu_result_out, d[i].lo); end
      funct_in = 6'h10; #1;
      checks++; if (alu_result_out !== d[i].hi) begin errors++; $display("FAIL div%0d_hi got %h want %h", i, alu_result_out, d[i].hi); end
    end
  endtask

  task automatic test_reset_mid_op();
    int n;
    @(negedge clk);
    clear_inputs();
    alu_op_in = 2'b10; funct_in = 6'h18; rdata1_in = 32'hFFFF_FFFD; rdata2_in = 32'd7;
    repeat (11) @(negedge clk);  // BUSY with count = 10
    checks++; if (ex_stall_out !== 1'b1) begin errors++; $display("FAIL rst_mid_busy got stall %0b want 1", ex_stall_out); end
    #1;
    rst_n = 0;
    clear_inputs();
    #1;
    checks++; if (ex_stall_out !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %0b want 0", ex_stall_out); end
    alu_op_in = 2'b10; funct_in = 6'h12; #1;
    checks++; if (alu_result_out !== 32'h0) begin errors++; $display("FAIL rst_mid_lo got %h want 0", alu_result_out); end
    funct_in = 6'h10; #1;
    checks++; if (alu_result_out !== 32'h0) begin errors++; $display("FAIL rst_mid_hi got %h want 0", alu_result_out); end
    @(negedge clk);
    rst_n = 1;
    clear_inputs();
    run_md(6'h19, 32'd6, 32'd7, n);
    checks++; if (n != 33) begin errors++; $display("FAIL rst_mid_idle_cycles got %0d want 33", n); end
    @(negedge clk);
    alu_op_in = 2'b10; funct_in = 6'h12; #1;
    checks++; if (alu_result_out !== 32'd42) begin errors++; $display("FAIL rst_mid_after_lo got %h want 0000002a", alu_result_out); end
  endtask

  task automatic test_jr_behind_muldiv();
    int n;
    int early;
    logic done;
    @(negedge clk);
    clear_inputs();
    alu_op_in = 2'b10; funct_in = 6'h1B; rdata1_in = 32'd100; rdata2_in = 32'd9;
    #1;
    n = (ex_stall_out === 1'b1) ? 1 : 0;
    early = 0;
    done = 0;
    @(negedge clk);
    if (ex_stall_out === 1'b1) n++;
    clear_inputs();
    jump_reg_in = 1; rdata1_in = 32'h0040_1000;
    #1;
    if (redirect_out !== 1'b0) early++;
    for (int g = 0; g < 100 && !done; g++) begin
      @(negedge clk);
      if (ex_stall_out === 1'b1) begin
        n++;
        if (redirect_out !== 1'b0) early++;
      end else begin
        done = 1;
      end
    end
    checks++; if (early != 0) begin errors++; $display("FAIL jr_early_redirect count %0d want 0", early); end
    checks++; if (n != 33) begin errors++; $display("FAIL jr_stall_cycles got %0d want 33", n); end
    checks++; if (redirect_out !== 1'b1 || redirect_pc_out !== 32'h0040_1000) begin errors++; $display("FAIL jr_after_done redirect %0b pc %h want 1 00401000", redirect_out, redirect_pc_out); end
    clear_inputs();
    @(negedge clk);
    alu_op_in = 2'b10; funct_in = 6'h12; #1;
    checks++; if (alu_result_out !== 32'd11) begin errors++; $display("FAIL jr_divu_lo got %h want 0000000b", alu_result_out); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu();
    test_branch();
    test_mult();
    test_div();
    test_reset_mid_op();
    test_jr_behind_muldiv();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
